// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types, defaults and mask helper for the pattern scan controller
package pattern_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int CNT_W_DEF = 8;
   localparam int LEN_W     = $clog2(PAT_W_DEF + 1);
   localparam int PAT_MAX   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   // Low-ones mask sized for the largest legal pattern; callers zero-extend into it.
   function automatic logic [PAT_MAX-1:0] mask(input int unsigned len);
      logic [PAT_MAX-1:0] m;
      for (int unsigned i = 0; i < PAT_MAX; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - history shift register, bits_seen counter and masked compare
module pattern_match_core #(
   parameter int PAT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       valid,
   input  logic                       in,
   input  logic [PAT_W-1:0]           pattern,
   input  logic [$clog2(PAT_W+1)-1:0] len,
   input  logic                       overlap,
   output logic                       hit
);
   import pattern_pkg::*;

   localparam int LW = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]   hist_q, hist_d, hist_shift;
   logic [LW-1:0]      seen_q, seen_d, seen_next;
   logic [PAT_MAX-1:0] diff;

   always_comb begin
      hist_d     = hist_q;
      seen_d     = seen_q;
      hist_shift = {hist_q[PAT_W-2:0], in};
      seen_next  = (seen_q == LW'(PAT_W)) ? seen_q : seen_q + 1'b1;
      diff       = PAT_MAX'(hist_shift ^ pattern) & mask(32'(len));
      hit        = valid && (seen_next >= len) && (diff == '0);
      if (clr) begin
         hist_d = '0;
         seen_d = '0;
      end else if (valid) begin
         hist_d = hist_shift;
         // Non-overlap mode keeps the stale history but refuses to count it again.
         seen_d = (hit && !overlap) ? '0 : seen_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_q <= '0;
         seen_q <= '0;
      end else begin
         hist_q <= hist_d;
         seen_q <= seen_d;
      end
   end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - run-controlled serial pattern scan: config, FSM, match counter
module pattern_scan_ctrl import pattern_pkg::*; #(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [PAT_W-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
   input  logic                       cfg_overlap,
   input  logic [CNT_W-1:0]           cfg_target,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       valid,
   input  logic                       in,
   output logic                       busy,
   output logic                       match,
   output logic [CNT_W-1:0]           match_cnt,
   output logic                       done,
   output logic                       err
);

   localparam int LW = $clog2(PAT_W + 1);

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [LW-1:0]    len_q, len_d;
   logic             ov_q, ov_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             match_q, match_d;
   logic             err_q, err_d;
   logic             start_used_q, start_used_d;
   logic             cfg_ok, core_clr, core_valid, hit;

   pattern_match_core #(.PAT_W(PAT_W)) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (core_clr),
      .valid   (core_valid),
      .in      (in),
      .pattern (pat_q),
      .len     (len_q),
      .overlap (ov_q),
      .hit     (hit)
   );

   assign core_valid = valid && (state_q == SCAN);
   assign cfg_ok     = (len_q != '0) && (len_q <= LW'(PAT_W)) && (tgt_q != '0);
   assign cnt_inc    = cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      pat_d        = pat_q;
      len_d        = len_q;
      ov_d         = ov_q;
      tgt_d        = tgt_q;
      cnt_d        = cnt_q;
      match_d      = 1'b0;
      err_d        = 1'b0;
      start_used_d = start_used_q;
      core_clr     = 1'b0;
      case (state_q)
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (hit) begin
               match_d = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == tgt_q) state_d = DONE;
            end
         end
         default: begin
            if (state_q == DONE && abort) begin
               state_d = IDLE;
            end else if (start && !start_used_q) begin
               // Start is judged against the registered config, never the one being written.
               if (!cfg_ok) begin
                  err_d        = 1'b1;
                  start_used_d = 1'b1;
               end else begin
                  core_clr = 1'b1;
                  cnt_d    = '0;
                  state_d  = SCAN;
               end
            end
            if (cfg_we) begin
               pat_d = cfg_pattern;
               len_d = cfg_len;
               ov_d  = cfg_overlap;
               tgt_d = cfg_target;
            end
         end
      endcase
      // A held start is consumed once; it re-arms when released or on a state change.
      if (!start || state_d != state_q) start_used_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         pat_q        <= '0;
         len_q        <= LW'(PAT_W);
         ov_q         <= 1'b1;
         tgt_q        <= CNT_W'(1);
         cnt_q        <= '0;
         match_q      <= 1'b0;
         err_q        <= 1'b0;
         start_used_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pat_q        <= pat_d;
         len_q        <= len_d;
         ov_q         <= ov_d;
         tgt_q        <= tgt_d;
         cnt_q        <= cnt_d;
         match_q      <= match_d;
         err_q        <= err_d;
         start_used_q <= start_used_d;
      end
   end

   assign busy      = (state_q == SCAN);
   assign done      = (state_q == DONE);
   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - directed and randomized bench with a bit-list reference model
module tb_pattern_scan_ctrl;

   localparam int PW = 8;
   localparam int CW = 8;
   localparam int LW = $clog2(PW + 1);

   logic          clk = 1'b0;
   logic          rst, cfg_we, cfg_overlap, start, abort, valid, in_bit;
   logic [PW-1:0] cfg_pattern;
   logic [LW-1:0] cfg_len;
   logic [CW-1:0] cfg_target;
   logic          busy, match, done, err;
   logic [CW-1:0] match_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: run state plus the list of bits received since the last restart.
   int      m_state;
   bit [PW-1:0] m_pat;
   int      m_len, m_tgt, m_cnt;
   bit      m_ov, m_match, m_err;
   bit      m_bits[$];

   always #5 clk = ~clk;

   pattern_scan_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .valid       (valid),
      .in          (in_bit),
      .busy        (busy),
      .match       (match),
      .match_cnt   (match_cnt),
      .done        (done),
      .err         (err)
   );

   function automatic bit tail_matches();
      if (m_bits.size() < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [CW+3:0] exp_vec();
      return {m_state == 1, m_state == 2, m_match, m_err, CW'(m_cnt)};
   endfunction

   task automatic step(input bit r, input bit we, input bit [PW-1:0] p, input int l,
                       input bit ov, input int t, input bit st, input bit ab,
                       input bit v, input bit b);
      @(negedge clk);
      rst = r; cfg_we = we; cfg_pattern = p; cfg_len = l[LW-1:0]; cfg_overlap = ov;
      cfg_target = t[CW-1:0]; start = st; abort = ab; valid = v; in_bit = b;
      @(posedge clk);
      #1;
      m_match = 1'b0;
      m_err   = 1'b0;
      if (!r) begin
         m_state = 0; m_cnt = 0; m_pat = '0; m_len = PW; m_ov = 1'b1; m_tgt = 1;
         m_bits.delete();
      end else if (m_state == 1) begin
         if (ab) begin
            m_state = 0;
         end else if (v) begin
            m_bits.push_back(b);
            if (m_bits.size() > 2 * PW) void'(m_bits.pop_front());
            if (tail_matches()) begin
               m_match = 1'b1;
               m_cnt++;
               if (!m_ov) m_bits.delete();
               if (m_cnt == m_tgt) m_state = 2;
            end
         end
      end else begin
         if (m_state == 2 && ab) begin
            m_state = 0;
         end else if (st) begin
            if (m_len >= 1 && m_len <= PW && m_tgt != 0) begin
               m_state = 1; m_cnt = 0; m_bits.delete();
            end else begin
               m_err = 1'b1;
            end
         end
         if (we) begin
            m_pat = p; m_len = l; m_ov = ov; m_tgt = t;
         end
      end
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({busy, done, match, err, match_cnt} !== '0) begin
         miscompares++;
         $display("FAIL reset: got %h want 0", {busy, done, match, err, match_cnt});
      end
   endtask

   task automatic test_overlap();
      bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
      step(1, 1, 8'b1011, 4, 1, 5, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, s[i]);
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec() || match !== (i == 3 || i == 6)) begin
            miscompares++;
            $display("FAIL overlap bit%0d: got %h want %h", i, {busy, done, match, err, match_cnt}, exp_vec());
         end
      end
      vectors++;
      if (match_cnt !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL overlap_end: cnt=%0d busy=%b done=%b want 2/1/0", match_cnt, busy, done);
      end
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_non_overlap();
      bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
      step(1, 1, 8'b1011, 4, 0, 5, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, s[i]);
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec() || match !== (i == 3)) begin
            miscompares++;
            $display("FAIL non_overlap bit%0d: got %h want %h", i, {busy, done, match, err, match_cnt}, exp_vec());
         end
      end
      vectors++;
      if (match_cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL non_overlap_end: cnt=%0d want 1", match_cnt);
      end
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_target_done();
      step(1, 1, 8'b11, 2, 1, 3, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec() || match !== (i >= 1 && i <= 3)
             || done !== (i >= 3)) begin
            miscompares++;
            $display("FAIL target bit%0d: got %h want %h", i, {busy, done, match, err, match_cnt}, exp_vec());
         end
      end
      vectors++;
      if (match_cnt !== 8'd3 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL target_end: cnt=%0d done=%b want 3/1", match_cnt, done);
      end
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || match_cnt !== 8'd0 || exp_vec() !== {busy, done, match, err, match_cnt}) begin
         miscompares++;
         $display("FAIL restart: busy=%b done=%b cnt=%0d want 1/0/0", busy, done, match_cnt);
      end
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_illegal();
      bit s[4] = '{1, 0, 1, 1};
      step(1, 1, 8'b1011, 0, 1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0 || exp_vec() !== {busy, done, match, err, match_cnt}) begin
         miscompares++;
         $display("FAIL len0: err=%b busy=%b want 1/0", err, busy);
      end
      step(1, 1, 8'b1011, 4, 1, 0, 0, 0, 0, 0);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_pulse: err=%b want 0", err);
      end
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0 || exp_vec() !== {busy, done, match, err, match_cnt}) begin
         miscompares++;
         $display("FAIL tgt0: err=%b busy=%b want 1/0", err, busy);
      end
      step(1, 1, 8'b1011, 4, 1, 5, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 1, 8'b0, 4, 1, 5, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, s[i]);
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec() || match !== (i == 3)) begin
            miscompares++;
            $display("FAIL cfg_in_scan bit%0d: got %h want %h", i, {busy, done, match, err, match_cnt}, exp_vec());
         end
      end
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_gaps_abort();
      bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
      step(1, 1, 8'b1011, 4, 1, 2, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, i == 6, 1, s[i]);
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec() || match !== (i == 3)) begin
            miscompares++;
            $display("FAIL gaps bit%0d: got %h want %h", i, {busy, done, match, err, match_cnt}, exp_vec());
         end
         if (i < 6) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1'($urandom));
      end
      vectors++;
      if (match_cnt !== 8'd1 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: cnt=%0d busy=%b done=%b want 1/0/0", match_cnt, busy, done);
      end
   endtask

   task automatic test_reset_mid_scan();
      step(1, 1, 8'b11, 2, 1, 5, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      vectors++;
      if ({busy, done, match, err, match_cnt} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid: got %h want 0", {busy, done, match, err, match_cnt});
      end
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < PW; i++) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec() || match !== (i == PW - 1)
             || done !== (i == PW - 1)) begin
            miscompares++;
            $display("FAIL default_cfg bit%0d: got %h want %h", i, {busy, done, match, err, match_cnt}, exp_vec());
         end
      end
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_random();
      bit prev_st = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         bit          we = ($urandom_range(0, 9) == 0);
         int          l  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
         int          t  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
         bit          st = !prev_st && ($urandom_range(0, 3) == 0);
         bit          ab = ($urandom_range(0, 24) == 0);
         bit          v  = ($urandom_range(0, 3) != 0);
         bit          b  = 1'($urandom);
         bit [PW-1:0] p  = PW'($urandom);
         step(1, we, p, l, 1'($urandom), t, st, ab, v, b);
         prev_st = st;
         vectors++;
         if ({busy, done, match, err, match_cnt} !== exp_vec()) begin
            miscompares++;
            $display("FAIL random n=%0d: got %h want %h", n, {busy, done, match, err, match_cnt}, exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      cfg_target = '0; start = 1'b0; abort = 1'b0; valid = 1'b0; in_bit = 1'b0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_target_done();
      test_illegal();
      test_gaps_abort();
      test_reset_mid_scan();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
